// File: rtl/baby_control_unit.sv
// Fetch/execute sequencer for the Baby datapath: steps CI_INC -> FETCH -> EXECUTE
// per instruction and decodes ALU, store and register-load strobes from state and FUNC.
module baby_control_unit #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   RUN,
    input  logic                   STEP,
    input  logic [2:0]             FUNC,
    input  logic                   ACC_SIGN,
    output logic [1:0]             ALU_A_SEL,
    output logic                   ALU_B_SEL,
    output logic                   ALU_SUB,
    output logic                   ALU_OE_n,
    output logic                   MEM_ADDR_SEL,
    output logic                   MEM_WE_n,
    output logic                   ACC_OE_n,
    output logic                   CI_LOAD,
    output logic                   PI_LOAD,
    output logic                   ACC_LOAD,
    output logic                   STOPPED,
    output logic [COUNT_WIDTH-1:0] INSTR_COUNT
);

    localparam logic [1:0] A_ZERO = 2'd0;
    localparam logic [1:0] A_ACC  = 2'd1;
    localparam logic [1:0] A_CI   = 2'd2;

    localparam logic [2:0] F_JMP = 3'd0;
    localparam logic [2:0] F_JRP = 3'd1;
    localparam logic [2:0] F_LDN = 3'd2;
    localparam logic [2:0] F_STO = 3'd3;
    localparam logic [2:0] F_SUB = 3'd4;
    localparam logic [2:0] F_SBB = 3'd5;
    localparam logic [2:0] F_CMP = 3'd6;
    localparam logic [2:0] F_STP = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CI_INC  = 2'd1,
        S_FETCH   = 2'd2,
        S_EXECUTE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_halt;
    logic                   w_halt_nxt;
    logic                   r_single;
    logic                   w_single_nxt;
    logic                   w_count_en;
    logic [COUNT_WIDTH-1:0] r_count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_halt   <= 1'b0;
            r_single <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_halt   <= w_halt_nxt;
            r_single <= w_single_nxt;
            if (w_count_en) begin
                r_count <= r_count + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_halt_nxt   = r_halt;
        w_single_nxt = r_single;
        w_count_en   = 1'b0;
        ALU_A_SEL    = A_ZERO;
        ALU_B_SEL    = 1'b0;
        ALU_SUB      = 1'b0;
        ALU_OE_n     = 1'b1;
        MEM_ADDR_SEL = 1'b0;
        MEM_WE_n     = 1'b1;
        ACC_OE_n     = 1'b1;
        CI_LOAD      = 1'b0;
        PI_LOAD      = 1'b0;
        ACC_LOAD     = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A halted machine only restarts once RUN has been seen low.
                if (!RUN) begin
                    w_halt_nxt = 1'b0;
                end
                if (STEP || (RUN && !r_halt)) begin
                    w_state_nxt  = S_CI_INC;
                    w_single_nxt = STEP && !RUN;
                end
            end

            S_CI_INC: begin
                ALU_A_SEL   = A_CI;
                ALU_B_SEL   = 1'b1;
                ALU_OE_n    = 1'b0;
                CI_LOAD     = 1'b1;
                w_state_nxt = S_FETCH;
            end

            S_FETCH: begin
                PI_LOAD     = 1'b1;
                w_state_nxt = S_EXECUTE;
            end

            S_EXECUTE: begin
                case (FUNC)
                    F_JMP: begin
                        ALU_OE_n     = 1'b0;
                        MEM_ADDR_SEL = 1'b1;
                        CI_LOAD      = 1'b1;
                    end
                    F_JRP: begin
                        ALU_A_SEL    = A_CI;
                        ALU_OE_n     = 1'b0;
                        MEM_ADDR_SEL = 1'b1;
                        CI_LOAD      = 1'b1;
                    end
                    F_LDN: begin
                        ALU_SUB      = 1'b1;
                        ALU_OE_n     = 1'b0;
                        MEM_ADDR_SEL = 1'b1;
                        ACC_LOAD     = 1'b1;
                    end
                    F_STO: begin
                        MEM_ADDR_SEL = 1'b1;
                        ACC_OE_n     = 1'b0;
                        MEM_WE_n     = 1'b0;
                    end
                    F_SUB, F_SBB: begin
                        ALU_A_SEL    = A_ACC;
                        ALU_SUB      = 1'b1;
                        ALU_OE_n     = 1'b0;
                        MEM_ADDR_SEL = 1'b1;
                        ACC_LOAD     = 1'b1;
                    end
                    F_CMP: begin
                        // Negative accumulator skips the next instruction via CI+1.
                        if (ACC_SIGN) begin
                            ALU_A_SEL = A_CI;
                            ALU_B_SEL = 1'b1;
                            ALU_OE_n  = 1'b0;
                            CI_LOAD   = 1'b1;
                        end
                    end
                    F_STP: begin
                        w_halt_nxt = 1'b1;
                    end
                    default: begin
                        w_halt_nxt = r_halt;
                    end
                endcase

                w_count_en = 1'b1;
                if ((FUNC == F_STP) || !RUN || r_single) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_CI_INC;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign STOPPED     = (r_state == S_IDLE);
    assign INSTR_COUNT = r_count;

endmodule

// File: tb/tb_baby_control_unit.sv
// Scoreboard bench for baby_control_unit: each driven cycle queues its expected
// strobe vector and instruction count; a negedge process pops and compares.
module tb_baby_control_unit;

    logic        CLK;
    logic        RESET;
    logic        RUN;
    logic        STEP;
    logic [2:0]  FUNC;
    logic        ACC_SIGN;
    logic [1:0]  ALU_A_SEL;
    logic        ALU_B_SEL;
    logic        ALU_SUB;
    logic        ALU_OE_n;
    logic        MEM_ADDR_SEL;
    logic        MEM_WE_n;
    logic        ACC_OE_n;
    logic        CI_LOAD;
    logic        PI_LOAD;
    logic        ACC_LOAD;
    logic        STOPPED;
    logic [15:0] INSTR_COUNT;

    logic [1:0]  w2_a_sel;
    logic        w2_b_sel;
    logic        w2_sub;
    logic        w2_alu_oe_n;
    logic        w2_addr_sel;
    logic        w2_we_n;
    logic        w2_acc_oe_n;
    logic        w2_ci_load;
    logic        w2_pi_load;
    logic        w2_acc_load;
    logic        w2_stopped;
    logic [1:0]  w2_count;

    baby_control_unit #(.COUNT_WIDTH(16)) u_dut (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .FUNC(FUNC), .ACC_SIGN(ACC_SIGN),
        .ALU_A_SEL(ALU_A_SEL), .ALU_B_SEL(ALU_B_SEL), .ALU_SUB(ALU_SUB), .ALU_OE_n(ALU_OE_n),
        .MEM_ADDR_SEL(MEM_ADDR_SEL), .MEM_WE_n(MEM_WE_n), .ACC_OE_n(ACC_OE_n),
        .CI_LOAD(CI_LOAD), .PI_LOAD(PI_LOAD), .ACC_LOAD(ACC_LOAD),
        .STOPPED(STOPPED), .INSTR_COUNT(INSTR_COUNT)
    );

    baby_control_unit #(.COUNT_WIDTH(2)) u_dut_w2 (
        .CLK(CLK), .RESET(RESET), .RUN(RUN), .STEP(STEP), .FUNC(FUNC), .ACC_SIGN(ACC_SIGN),
        .ALU_A_SEL(w2_a_sel), .ALU_B_SEL(w2_b_sel), .ALU_SUB(w2_sub), .ALU_OE_n(w2_alu_oe_n),
        .MEM_ADDR_SEL(w2_addr_sel), .MEM_WE_n(w2_we_n), .ACC_OE_n(w2_acc_oe_n),
        .CI_LOAD(w2_ci_load), .PI_LOAD(w2_pi_load), .ACC_LOAD(w2_acc_load),
        .STOPPED(w2_stopped), .INSTR_COUNT(w2_count)
    );

    typedef struct {
        string       tag;
        logic [11:0] vec;
        int          cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Vector layout: A_SEL[11:10] B_SEL SUB ALU_OE_n ADDR_SEL WE_n ACC_OE_n CI PI ACC STOPPED
    function automatic logic [11:0] mk(input logic [1:0] a, input logic b, input logic s,
                                       input logic oe, input logic ad, input logic we,
                                       input logic aoe, input logic ci, input logic pi,
                                       input logic acc, input logic stop);
        return {a, b, s, oe, ad, we, aoe, ci, pi, acc, stop};
    endfunction

    function automatic logic [11:0] v_idle();
        return mk(2'd0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1);
    endfunction

    function automatic logic [11:0] v_ci();
        return mk(2'd2, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0);
    endfunction

    function automatic logic [11:0] v_fetch();
        return mk(2'd0, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0);
    endfunction

    function automatic logic [11:0] v_exec(input logic [2:0] f, input logic sign);
        case (f)
            3'd0:    return mk(2'd0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
            3'd1:    return mk(2'd2, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0);
            3'd2:    return mk(2'd0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0);
            3'd3:    return mk(2'd0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
            3'd4,
            3'd5:    return mk(2'd1, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0);
            3'd6:    return sign ? mk(2'd2, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0)
                                 : mk(2'd0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
            default: return mk(2'd0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0);
        endcase
    endfunction

    function automatic logic [11:0] obs_vec();
        return {ALU_A_SEL, ALU_B_SEL, ALU_SUB, ALU_OE_n, MEM_ADDR_SEL, MEM_WE_n,
                ACC_OE_n, CI_LOAD, PI_LOAD, ACC_LOAD, STOPPED};
    endfunction

    task automatic tick(input logic run, input logic step, input logic [2:0] func,
                        input logic sign, input logic [11:0] ev, input int cnt,
                        input string tag);
        exp_t e;
        @(posedge CLK);
        #1;
        RUN      = run;
        STEP     = step;
        FUNC     = func;
        ACC_SIGN = sign;
        e.tag = tag;
        e.vec = ev;
        e.cnt = cnt;
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.tag, "_out"}, 32'(obs_vec()), 32'(e.vec));
            check({e.tag, "_cnt"}, 32'(INSTR_COUNT), 32'(e.cnt));
            check({e.tag, "_cnt2"}, 32'(w2_count), 32'(e.cnt % 4));
            check({e.tag, "_oe_excl"}, 32'(ALU_OE_n | ACC_OE_n), 32'd1);
        end
    end

    initial begin
        RESET    = 1'b0;
        RUN      = 1'b0;
        STEP     = 1'b0;
        FUNC     = 3'd0;
        ACC_SIGN = 1'b0;
        #1 RESET = 1'b1;
        #2;
        check("reset_out", 32'(obs_vec()), 32'(v_idle()));
        check("reset_cnt", 32'(INSTR_COUNT), 32'd0);
        @(posedge CLK);
        #1 RESET = 1'b0;

        for (int i = 0; i < 10; i++) tick(0, 0, 3'd0, 0, v_idle(), 0, "idle");

        // Single step LDN
        tick(0, 1, 3'd2, 0, v_idle(), 0, "ldn_idle");
        tick(0, 0, 3'd2, 0, v_ci(), 0, "ldn_ci");
        tick(0, 0, 3'd2, 0, v_fetch(), 0, "ldn_fetch");
        tick(0, 0, 3'd2, 0, v_exec(3'd2, 0), 0, "ldn_exec");
        tick(0, 0, 3'd2, 0, v_idle(), 1, "ldn_done");
        tick(0, 0, 3'd2, 0, v_idle(), 1, "ldn_done2");

        // Run SUB, STO, JRP; STEP while running is ignored; RUN drops in the last FETCH
        tick(1, 0, 3'd4, 0, v_idle(), 1, "run_idle");
        tick(1, 0, 3'd4, 0, v_ci(), 1, "sub_ci");
        tick(1, 0, 3'd4, 0, v_fetch(), 1, "sub_fetch");
        tick(1, 0, 3'd4, 0, v_exec(3'd4, 0), 1, "sub_exec");
        tick(1, 1, 3'd3, 0, v_ci(), 2, "sto_ci");
        tick(1, 0, 3'd3, 0, v_fetch(), 2, "sto_fetch");
        tick(1, 1, 3'd3, 0, v_exec(3'd3, 0), 2, "sto_exec");
        tick(1, 0, 3'd1, 0, v_ci(), 3, "jrp_ci");
        tick(0, 0, 3'd1, 0, v_fetch(), 3, "jrp_fetch");
        tick(0, 0, 3'd1, 0, v_exec(3'd1, 0), 3, "jrp_exec");
        tick(0, 0, 3'd1, 0, v_idle(), 4, "run_done");

        // CMP taken then not taken
        tick(1, 0, 3'd6, 1, v_idle(), 4, "cmp_idle");
        tick(1, 0, 3'd6, 1, v_ci(), 4, "cmp1_ci");
        tick(1, 0, 3'd6, 1, v_fetch(), 4, "cmp1_fetch");
        tick(1, 0, 3'd6, 1, v_exec(3'd6, 1), 4, "cmp1_exec");
        tick(1, 0, 3'd6, 0, v_ci(), 5, "cmp0_ci");
        tick(1, 0, 3'd6, 0, v_fetch(), 5, "cmp0_fetch");
        tick(0, 0, 3'd6, 0, v_exec(3'd6, 0), 5, "cmp0_exec");
        tick(0, 0, 3'd6, 0, v_idle(), 6, "cmp_done");

        // STP with RUN held, then RUN low/high restarts
        tick(1, 0, 3'd7, 0, v_idle(), 6, "stp_idle");
        tick(1, 0, 3'd7, 0, v_ci(), 6, "stp_ci");
        tick(1, 0, 3'd7, 0, v_fetch(), 6, "stp_fetch");
        tick(1, 0, 3'd7, 0, v_exec(3'd7, 0), 6, "stp_exec");
        for (int i = 0; i < 5; i++) tick(1, 0, 3'd7, 0, v_idle(), 7, "halted");
        tick(0, 0, 3'd7, 0, v_idle(), 7, "run_low");
        tick(1, 0, 3'd0, 0, v_idle(), 7, "run_high");
        tick(1, 0, 3'd0, 0, v_ci(), 7, "jmp_ci");
        tick(0, 0, 3'd0, 0, v_fetch(), 7, "jmp_fetch");
        tick(0, 0, 3'd0, 0, v_exec(3'd0, 0), 7, "jmp_exec");
        tick(0, 0, 3'd0, 0, v_idle(), 8, "jmp_done");

        // Reset asserted during FETCH aborts immediately
        tick(1, 0, 3'd2, 0, v_idle(), 8, "rf_idle");
        tick(1, 0, 3'd2, 0, v_ci(), 8, "rf_ci");
        @(posedge CLK);
        #1;
        check("rf_pre_out", 32'(obs_vec()), 32'(v_fetch()));
        RESET = 1'b1;
        #1;
        check("rf_out", 32'(obs_vec()), 32'(v_idle()));
        check("rf_pi_load", 32'(PI_LOAD), 32'd0);
        check("rf_cnt", 32'(INSTR_COUNT), 32'd0);
        check("rf_cnt2", 32'(w2_count), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        RUN   = 1'b0;
        tick(0, 0, 3'd2, 0, v_idle(), 0, "rf_after");
        tick(0, 0, 3'd2, 0, v_idle(), 0, "rf_after2");

        @(negedge CLK);
        @(negedge CLK);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
